// File: rtl/snd_pkg.sv
// snd_pkg: shared FSM states, event indices and default timing for the sound event sequencer
package snd_pkg;
   typedef enum logic [1:0] {IDLE, START, PLAY, GAP} state_t;
   localparam int NUM_EVT           = 5;
   localparam int EV_DEATH          = 0;
   localparam int EV_INTRO          = 1;
   localparam int EV_EATGHOST       = 2;
   localparam int EV_EATFRUIT       = 3;
   localparam int EV_EXTRAPAC       = 4;
   localparam int DEF_GAP_CYCLES    = 8;
   localparam int DEF_START_TIMEOUT = 16;
   localparam int DEF_WAKA_HOLD     = 2000000;
   function automatic int max2(input int a, input int b);
      return a > b ? a : b;
   endfunction
endpackage

// File: rtl/snd_event_latch.sv
// snd_event_latch: pending event register with death-clear, drop detection and fixed-priority pick
module snd_event_latch
   import snd_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_EVT-1:0] evt,
   input  logic [NUM_EVT-1:0] take,
   input  logic [NUM_EVT-1:0] playing,
   output logic [NUM_EVT-1:0] pending,
   output logic [NUM_EVT-1:0] pend_nxt,
   output logic [NUM_EVT-1:0] pick,
   output logic               dropped
);
   localparam logic [NUM_EVT-1:0] LOWER = ~(NUM_EVT'(1) << EV_DEATH);
   logic [NUM_EVT-1:0] kept, killed, dup;
   always_comb begin
      kept     = pending & ~take;
      killed   = evt[EV_DEATH] ? kept & LOWER : '0;
      dup      = evt & (kept | playing);
      pend_nxt = (kept & ~killed) | evt;
      pick     = pending & (~pending + NUM_EVT'(1));
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         pending <= '0;
         dropped <= 1'b0;
      end else begin
         pending <= pend_nxt;
         dropped <= |(dup | killed);
      end
endmodule

// File: rtl/snd_event_sequencer.sv
// snd_event_sequencer: game-event pulses to held one-hot sound selects; SND_PREEMPT_EN lets death preempt
module snd_event_sequencer
   import snd_pkg::*;
#(
   parameter int GAP_CYCLES    = DEF_GAP_CYCLES,
   parameter int START_TIMEOUT = DEF_START_TIMEOUT,
   parameter int WAKA_HOLD     = DEF_WAKA_HOLD
)(
   input  logic clk,
   input  logic reset,
   input  logic evt_intro,
   input  logic evt_eatghost,
   input  logic evt_death,
   input  logic evt_eatfruit,
   input  logic evt_extrapac,
   input  logic dot_eaten,
   input  logic soundEnded,
   output logic Sw_intro,
   output logic Sw_eatghost,
   output logic Sw_death,
   output logic Sw_eatfruit,
   output logic extrapac6_btnr,
   output logic Sw_waka,
   output logic busy,
   output logic dropped
);
`ifdef SND_PREEMPT_EN
   localparam bit PREEMPT = 1'b1;
`else
   localparam bit PREEMPT = 1'b0;
`endif
   localparam int CW = $clog2(max2(GAP_CYCLES, START_TIMEOUT) + 1);
   localparam int WW = $clog2(WAKA_HOLD + 1);
   state_t             state, state_n;
   logic [CW-1:0]      cnt, cnt_n;
   logic [WW-1:0]      wcnt, wcnt_n;
   logic [NUM_EVT-1:0] evt, sel, sel_n, take, pending, pend_nxt, pick;
   logic               waka_q;
   assign evt[EV_DEATH]    = evt_death;
   assign evt[EV_INTRO]    = evt_intro;
   assign evt[EV_EATGHOST] = evt_eatghost;
   assign evt[EV_EATFRUIT] = evt_eatfruit;
   assign evt[EV_EXTRAPAC] = evt_extrapac;
   snd_event_latch u_latch (
      .clk      (clk),
      .reset    (reset),
      .evt      (evt),
      .take     (take),
      .playing  (sel),
      .pending  (pending),
      .pend_nxt (pend_nxt),
      .pick     (pick),
      .dropped  (dropped)
   );
   always_comb begin
      state_n = state;
      sel_n   = sel;
      cnt_n   = cnt;
      take    = '0;
      case (state)
         IDLE:
            if (|pending) begin
               take    = pick;
               sel_n   = pick;
               state_n = START;
               cnt_n   = '0;
            end
         START:
            if (!soundEnded || cnt == CW'(START_TIMEOUT - 1)) begin
               state_n = PLAY;
               cnt_n   = '0;
            end else
               cnt_n = cnt + CW'(1);
         PLAY:
            if (soundEnded) begin
               sel_n   = '0;
               state_n = GAP;
               cnt_n   = '0;
            end
         GAP:
            if (cnt == CW'(GAP_CYCLES - 1)) begin
               state_n = IDLE;
               cnt_n   = '0;
            end else
               cnt_n = cnt + CW'(1);
      endcase
      // a preempted sound is abandoned; death stays pending and is served after the gap
      if (PREEMPT && (state == START || state == PLAY) && evt_death && !sel[EV_DEATH]) begin
         sel_n   = '0;
         state_n = GAP;
         cnt_n   = '0;
      end
   end
   assign wcnt_n = dot_eaten ? WW'(WAKA_HOLD) : (wcnt != '0 ? wcnt - WW'(1) : '0);
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state  <= IDLE;
         sel    <= '0;
         cnt    <= '0;
         wcnt   <= '0;
         waka_q <= 1'b0;
      end else begin
         state  <= state_n;
         sel    <= sel_n;
         cnt    <= cnt_n;
         wcnt   <= wcnt_n;
         waka_q <= wcnt_n != '0 && state_n == IDLE && pend_nxt == '0;
      end
   assign Sw_death       = sel[EV_DEATH];
   assign Sw_intro       = sel[EV_INTRO];
   assign Sw_eatghost    = sel[EV_EATGHOST];
   assign Sw_eatfruit    = sel[EV_EATFRUIT];
   assign extrapac6_btnr = sel[EV_EXTRAPAC];
   assign Sw_waka        = waka_q;
   assign busy           = state != IDLE;
endmodule

// File: tb/tb_snd_event_sequencer.sv
// tb_snd_event_sequencer: directed and randomized checks against a behavioural sequencer model
module tb_snd_event_sequencer;
   localparam int GAP = 8, TO = 16, HOLD = 100;
   localparam int P_IDLE = 0, P_START = 1, P_PLAY = 2, P_GAP = 3;
`ifdef SND_PREEMPT_EN
   localparam bit PREEMPT = 1'b1;
`else
   localparam bit PREEMPT = 1'b0;
`endif
   logic       clk = 1'b0, reset = 1'b1, dot = 1'b0, se = 1'b1;
   logic [4:0] ev = '0;
   logic       Sw_intro, Sw_eatghost, Sw_death, Sw_eatfruit, extrapac6_btnr, Sw_waka, busy, dropped;
   logic [4:0] sel_got;
   int         tests = 0, fails = 0;
   int         m_ph, m_cur, m_cnt, m_w;
   bit   [4:0] m_pend;
   bit         m_drop;
   always #5 clk = ~clk;
   assign sel_got = {extrapac6_btnr, Sw_eatfruit, Sw_eatghost, Sw_intro, Sw_death};
   snd_event_sequencer #(.GAP_CYCLES(GAP), .START_TIMEOUT(TO), .WAKA_HOLD(HOLD)) dut (
      .clk            (clk),
      .reset          (reset),
      .evt_intro      (ev[1]),
      .evt_eatghost   (ev[2]),
      .evt_death      (ev[0]),
      .evt_eatfruit   (ev[3]),
      .evt_extrapac   (ev[4]),
      .dot_eaten      (dot),
      .soundEnded     (se),
      .Sw_intro       (Sw_intro),
      .Sw_eatghost    (Sw_eatghost),
      .Sw_death       (Sw_death),
      .Sw_eatfruit    (Sw_eatfruit),
      .extrapac6_btnr (extrapac6_btnr),
      .Sw_waka        (Sw_waka),
      .busy           (busy),
      .dropped        (dropped)
   );
   task automatic check(input string tag, input int got, input int exp);
      tests++;
      if (got != exp) begin
         fails++;
         $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, got, exp);
      end
   endtask
   task automatic model_reset();
      m_ph = P_IDLE; m_cur = -1; m_cnt = 0; m_w = 0; m_pend = '0; m_drop = 0;
   endtask
   task automatic model_step();
      int t, cur0;
      bit play;
      t = -1; cur0 = m_cur; m_drop = 0;
      play = m_ph == P_START || m_ph == P_PLAY;
      if (m_ph == P_IDLE) for (int i = 4; i >= 0; i--) if (m_pend[i]) t = i;
      if (t >= 0) m_pend[t] = 0;
      for (int i = 0; i < 5; i++) if (ev[i] && (m_pend[i] || (play && cur0 == i))) m_drop = 1;
      if (ev[0]) for (int i = 1; i < 5; i++) if (m_pend[i]) begin m_drop = 1; m_pend[i] = 0; end
      m_pend |= ev;
      m_w = dot ? HOLD : (m_w > 0 ? m_w - 1 : 0);
      case (m_ph)
         P_IDLE:  if (t >= 0) begin m_cur = t; m_ph = P_START; m_cnt = 1; end
         P_START: if (!se || m_cnt == TO) m_ph = P_PLAY; else m_cnt++;
         P_PLAY:  if (se) begin m_ph = P_GAP; m_cnt = 1; m_cur = -1; end
         default: if (m_cnt == GAP) m_ph = P_IDLE; else m_cnt++;
      endcase
      if (PREEMPT && play && ev[0] && cur0 != 0) begin m_ph = P_GAP; m_cnt = 1; m_cur = -1; end
   endtask
   task automatic compare();
      bit [4:0] es;
      es = (m_ph == P_START || m_ph == P_PLAY) ? 5'(1) << m_cur : '0;
      check("sel", sel_got, es);
      check("onehot", $onehot0(sel_got), 1);
      check("busy", busy, m_ph != P_IDLE);
      check("dropped", dropped, m_drop);
      check("waka", Sw_waka, m_w != 0 && m_ph == P_IDLE && m_pend == 0);
   endtask
   task automatic step();
      @(posedge clk);
      model_step();
      #1;
      compare();
   endtask
   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask
   task automatic pulse(input logic [4:0] e);
      ev = e;
      step();
      ev = '0;
   endtask
   initial begin
      int n, r;
      model_reset();
      #12;
      check("rst_sel", sel_got, 0);
      check("rst_busy", busy, 0);
      check("rst_waka", Sw_waka, 0);
      check("rst_drop", dropped, 0);
      #11 reset = 1'b0;
      run(9);
      pulse(5'b01000);
      check("fruit_lat1", Sw_eatfruit, 0);
      step();
      check("fruit_lat2", Sw_eatfruit, 1);
      run(1);
      se = 1'b0;
      run(185);
      se = 1'b1;
      step();
      check("fruit_end", Sw_eatfruit, 0);
      for (int i = 0; i < 7; i++) begin step(); check("gap_busy", busy, 1); end
      step();
      check("gap_idle", busy, 0);
      pulse(5'b10100);
      step();
      check("ghost_first", Sw_eatghost, 1);
      check("xp_wait", extrapac6_btnr, 0);
      run(2);
      se = 1'b0;
      run(20);
      se = 1'b1;
      step();
      check("ghost_end", Sw_eatghost, 0);
      n = 0;
      for (int i = 0; i < 50 && !extrapac6_btnr; i++) begin step(); n++; end
      check("xp_after_gap", n, 9);
      se = 1'b0;
      run(3);
      se = 1'b1;
      run(12);
      pulse(5'b00100);
      step();
      se = 1'b0;
      run(3);
      pulse(5'b01000);
      run(3);
      pulse(5'b00001);
      check("death_drop", dropped, 1);
      check("preempt", Sw_eatghost, !PREEMPT);
      step();
      check("drop_once", dropped, 0);
      se = 1'b1;
      n = 0;
      for (int i = 0; i < 60; i++) begin step(); n += Sw_death; end
      check("death_len", n, 17);
      pulse(5'b00010);
      n = 0;
      for (int i = 0; i < 60; i++) begin step(); n += Sw_intro; end
      check("timeout_len", n, 17);
      check("to_idle", busy, 0);
      dot = 1'b1;
      step();
      dot = 1'b0;
      n = 0;
      for (int i = 0; i < 200 && Sw_waka; i++) begin n++; step(); end
      check("waka_len", n, 100);
      dot = 1'b1;
      step();
      dot = 1'b0;
      run(20);
      pulse(5'b01000);
      check("waka_sup", Sw_waka, 0);
      run(40);
      check("waka_resume", Sw_waka, 1);
      run(50);
      pulse(5'b00100);
      step();
      se = 1'b0;
      run(3);
      #2 reset = 1'b1;
      #1;
      check("rst_mid_sel", sel_got, 0);
      check("rst_mid_busy", busy, 0);
      @(posedge clk);
      @(posedge clk);
      #2 reset = 1'b0;
      se = 1'b1;
      model_reset();
      run(5);
      check("post_rst_idle", busy, 0);
      for (int c = 0; c < 4000; c++) begin
         r = $urandom_range(0, 59);
         ev = r < 5 ? 5'(1) << r : (r == 5 ? 5'($urandom) & 5'b11110 : 5'b0);
         dot = $urandom_range(0, 79) == 0;
         if ($urandom_range(0, 24) == 0) se = ~se;
         step();
      end
      ev = '0;
      dot = 1'b0;
      run(5);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
